sram_axi_master: RTL and testbench

SRAM_AXI_MASTER -- requirements
Module: sram_axi_master

---
 rtl/sram_axi_master_pkg.sv | 45 ++++
 rtl/sram_axi_master.sv | 227 ++++++++++++++++++++++
 tb/tb_sram_axi_master.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_master_pkg.sv
// sram_axi_master_pkg
//   Shared definitions for the SRAM-style to AXI3 master bridge:
//   AXI channel field widths, client bus widths, the FSM state type and
//   a helper that maps the client size code onto an AXI size field.
package sram_axi_master_pkg;

  // AXI3 channel field widths
  localparam int LARID    = 4;
  localparam int LARADDR  = 32;
  localparam int LARLEN   = 4;
  localparam int LARSIZE  = 3;
  localparam int LARBURST = 2;
  localparam int LARLOCK  = 2;
  localparam int LARCACHE = 4;
  localparam int LARPROT  = 3;
  localparam int LRID     = 4;
  localparam int LRDATA   = 32;
  localparam int LRRESP   = 2;
  localparam int LAWID    = 4;
  localparam int LWID     = 4;
  localparam int LWDATA   = 32;
  localparam int LWSTRB   = 4;
  localparam int LBID     = 4;
  localparam int LBRESP   = 2;

  // Client side widths
  localparam int BUS_WIDTH  = 32;
  localparam int DATA_WIDTH = 32;

  // Single-outstanding-transaction controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4
  } state_e;

  // Client size code 3 has no 8-byte meaning on a 32-bit bus; it is
  // issued as a 4-byte access.
  function automatic logic [LARSIZE-1:0] axi_size(input logic [1:0] size);
    return (size == 2'd3) ? 3'b010 : {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_master.sv
// sram_axi_master
//   Converts a simple SRAM-like request/response client port into single
//   beat AXI3 read and write transactions. At most one transaction is in
//   flight; the client sees addr_ok while idle and a one-cycle data_ok
//   pulse when the transaction completes.
//
// Ports
//   aclk, aresetn              clock, synchronous active-low reset
//   req, wr, size, addr,       client request (accepted when req && addr_ok)
//   req_wdata, req_wstrb       client write data / byte enables
//   addr_ok, data_ok,          client accept / completion pulse
//   rsp_rdata, resp_err        read data (held) / error flag (with data_ok)
//   dbg_state                  current FSM state (state_e encoding)
//   ar*/r*/aw*/w*/b*           AXI3 master channels
//
// Handshake rule: a transfer happens on a rising edge where valid and
// ready are both high; a valid, once raised, stays high with its payload
// stable until that edge, and ready signals are only raised in the state
// that owns the channel.
module sram_axi_master
  import sram_axi_master_pkg::*;
#(
  parameter logic [LARID-1:0] ARID = 4'd0,
  parameter logic [LAWID-1:0] AWID = 4'd1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // client port
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [BUS_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  resp_err,
  output logic [2:0]            dbg_state,
  // AR
  output logic [LARID-1:0]      arid,
  output logic [LARADDR-1:0]    araddr,
  output logic [LARLEN-1:0]     arlen,
  output logic [LARSIZE-1:0]    arsize,
  output logic [LARBURST-1:0]   arburst,
  output logic [LARLOCK-1:0]    arlock,
  output logic [LARCACHE-1:0]   arcache,
  output logic [LARPROT-1:0]    arprot,
  output logic                  arvalid,
  input  logic                  arready,
  // R
  input  logic [LRID-1:0]       rid,
  input  logic [LRDATA-1:0]     rdata,
  input  logic [LRRESP-1:0]     rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AW
  output logic [LAWID-1:0]      awid,
  output logic [LARADDR-1:0]    awaddr,
  output logic [LARLEN-1:0]     awlen,
  output logic [LARSIZE-1:0]    awsize,
  output logic [LARBURST-1:0]   awburst,
  output logic [LARLOCK-1:0]    awlock,
  output logic [LARCACHE-1:0]   awcache,
  output logic [LARPROT-1:0]    awprot,
  output logic                  awvalid,
  input  logic                  awready,
  // W
  output logic [LWID-1:0]       wid,
  output logic [LWDATA-1:0]     wdata,
  output logic [LWSTRB-1:0]     wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // B
  input  logic [LBID-1:0]       bid,
  input  logic [LBRESP-1:0]     bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  state_e                  state_q, state_d;
  logic [BUS_WIDTH-1:0]    addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    wr_q, wr_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    data_ok_q, data_ok_d;
  logic                    resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    aw_now, w_now;

  // Single-beat transactions never need rlast; it is accepted but ignored.
  logic unused_rlast;
  assign unused_rlast = rlast;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_d       = wr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    data_ok_d  = 1'b0;
    resp_err_d = 1'b0;
    rdata_d    = rdata_q;
    // A channel counts as done if it finished earlier or finishes now.
    aw_now     = aw_done_q | (awvalid & awready);
    w_now      = w_done_q | (wvalid & wready);
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d    = addr;
          size_d    = size;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          wr_d      = wr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = wr ? ST_WADDR : ST_RADDR;
        end
      end
      ST_RADDR: begin
        if (arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (rvalid) begin
          state_d    = ST_IDLE;
          data_ok_d  = 1'b1;
          rdata_d    = rdata;
          resp_err_d = (rresp != 2'b00) || (rid != ARID);
        end
      end
      ST_WADDR: begin
        if (aw_now && w_now) begin
          state_d   = ST_WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      ST_WRESP: begin
        if (bvalid) begin
          state_d    = ST_IDLE;
          data_ok_d  = 1'b1;
          resp_err_d = (bresp != 2'b00) || (bid != AWID);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_q       <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      data_ok_q  <= 1'b0;
      resp_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_q       <= wr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      data_ok_q  <= data_ok_d;
      resp_err_q <= resp_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Client side
  assign addr_ok   = (state_q == ST_IDLE);
  assign data_ok   = data_ok_q;
  assign resp_err  = resp_err_q;
  assign rsp_rdata = rdata_q;
  assign dbg_state = state_q;

  // AR: payload comes straight from the captured request
  assign arid    = ARID;
  assign araddr  = addr_q;
  assign arlen   = '0;
  assign arsize  = axi_size(size_q);
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (state_q == ST_RADDR) && !wr_q;

  assign rready  = (state_q == ST_RDATA);

  // AW / W run independently inside WADDR
  assign awid    = AWID;
  assign awaddr  = addr_q;
  assign awlen   = '0;
  assign awsize  = axi_size(size_q);
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = (state_q == ST_WADDR) && !aw_done_q;

  assign wid     = AWID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == ST_WADDR) && !w_done_q;

  assign bready  = (state_q == ST_WRESP);

endmodule

// File: tb/tb_sram_axi_master.sv
// tb_sram_axi_master
//   Directed bench for sram_axi_master. A small byte-addressed AXI slave
//   with per-channel ready/valid delays answers the DUT; each scenario task
//   drives the client port and checks results against hand-computed values.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_axi_master;
  import sram_axi_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic rst_seen = 1'b1;
  always @(posedge aclk) rst_seen <= !aresetn;

  // ---------------- DUT signals ----------------
  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        addr_ok, data_ok, resp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  dbg_state;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

  sram_axi_master #(.ARID(4'd0), .AWID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req(req), .wr(wr), .size(size), .addr(addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .addr_ok(addr_ok), .data_ok(data_ok), .rsp_rdata(rsp_rdata),
    .resp_err(resp_err), .dbg_state(dbg_state),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // ---------------- AXI slave model ----------------
  int ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
  logic [1:0] r_resp_k = 2'b00, b_resp_k = 2'b00;
  logic [3:0] r_id_k = 4'd0, b_id_k = 4'd1;

  logic [7:0] mem [0:1023];
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  bit ar_fire = 0, aw_fire = 0, w_fire = 0, r_fire = 0, b_fire = 0;
  bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] ar_addr_l = '0, aw_addr_l = '0, w_data_l = '0;
  logic [3:0]  w_strb_l = '0;

  always @(negedge aclk) begin
    int base;
    // Flags computed last falling edge describe the rising edge just past.
    if (rst_seen) begin
      ar_fire = 0; aw_fire = 0; w_fire = 0; r_fire = 0; b_fire = 0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    end
    if (ar_fire) begin r_pend = 1; r_cnt = 0; end
    if (aw_fire) aw_got = 1;
    if (w_fire)  w_got = 1;
    if (r_fire)  r_pend = 0;
    if (b_fire)  b_pend = 0;
    if (aw_got && w_got) begin
      base = int'({aw_addr_l[9:2], 2'b00});
      for (int i = 0; i < 4; i++)
        if (w_strb_l[i]) mem[base + i] = w_data_l[8*i +: 8];
      aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
    end
    // AR
    arready = arvalid && (ar_cnt >= ar_delay);
    if (arvalid && !arready) ar_cnt++; else ar_cnt = 0;
    ar_fire = arvalid && arready;
    if (ar_fire) ar_addr_l = araddr;
    // AW
    awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
    if (awvalid && !awready) aw_cnt++; else aw_cnt = 0;
    aw_fire = awvalid && awready;
    if (aw_fire) aw_addr_l = awaddr;
    // W
    wready = wvalid && !w_got && (w_cnt >= w_delay);
    if (wvalid && !wready) w_cnt++; else w_cnt = 0;
    w_fire = wvalid && wready;
    if (w_fire) begin w_data_l = wdata; w_strb_l = wstrb; end
    // R
    rvalid = r_pend && (r_cnt >= r_delay);
    if (r_pend && !rvalid) r_cnt++;
    base  = int'({ar_addr_l[9:2], 2'b00});
    rdata = {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
    rresp = r_resp_k;
    rid   = r_id_k;
    rlast = rvalid;
    r_fire = rvalid && rready;
    // B
    bvalid = b_pend && (b_cnt >= b_delay);
    if (b_pend && !bvalid) b_cnt++;
    bresp = b_resp_k;
    bid   = b_id_k;
    b_fire = bvalid && bready;
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output bit ok, output int acc);
    req = 1'b1; wr = w; size = sz; addr = a; req_wdata = d; req_wstrb = s;
    ok = 0; acc = -1;
    for (int i = 0; i < 40; i++) begin
      if (addr_ok === 1'b1) begin ok = 1; acc = cyc; end
      @(negedge aclk);
      if (ok) break;
    end
    req = 1'b0;
  endtask

  // Returns on the falling edge of the cycle where data_ok is seen.
  task automatic wait_done(output bit ok, output int at,
                           output logic [31:0] rd, output logic er);
    ok = 0; at = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (data_ok === 1'b1) begin ok = 1; at = cyc; rd = rsp_rdata; er = resp_err; break; end
      @(negedge aclk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL reset_addr_ok: got %b expected 1", addr_ok); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_cmp++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valid_ready: got %b expected 00000", {arvalid, awvalid, wvalid, rready, bready}); end
    n_cmp++; if ({data_ok, resp_err} !== 2'b00) begin
      n_bad++; $display("FAIL reset_data_ok_err: got %b expected 00", {data_ok, resp_err}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata); end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_read_zero_wait();
    bit ok; int acc, at; logic [31:0] rd; logic er;
    mem[256] = 8'hEF; mem[257] = 8'hBE; mem[258] = 8'hAD; mem[259] = 8'hDE;
    issue(1'b0, 2'd2, 32'h100, 32'h0, 4'h0, ok, acc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd_accept: got timeout expected accept"); end
    n_cmp++; if ({arvalid, addr_ok} !== 2'b10) begin n_bad++; $display("FAIL rd_arvalid_t1: got %b expected 10", {arvalid, addr_ok}); end
    n_cmp++; if (araddr !== 32'h100 || arsize !== 3'b010 || arid !== 4'd0) begin
      n_bad++; $display("FAIL rd_ar_fields: got addr=%h size=%b id=%h expected 00000100/010/0", araddr, arsize, arid); end
    n_cmp++; if ({arlen, arburst, arlock, arcache, arprot} !== {4'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
      n_bad++; $display("FAIL rd_ar_fixed: got %h expected %h", {arlen, arburst, arlock, arcache, arprot}, {4'd0, 2'b01, 2'b00, 4'd0, 3'd0}); end
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok || at != acc + 3) begin n_bad++; $display("FAIL rd_latency: got cycle %0d expected %0d", at, acc + 3); end
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL rd_data: got %h err=%b expected deadbeef err=0", rd, er); end
    @(negedge aclk);
    n_cmp++; if (data_ok !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rd_pulse_hold: got data_ok=%b rdata=%h expected 0/deadbeef", data_ok, rsp_rdata); end
  endtask

  task automatic test_write_w_first();
    bit ok; int acc, at, pulses; bit hold_ok; logic [31:0] rd; logic er;
    for (int i = 516; i < 520; i++) mem[i] = 8'hAA;
    mem[515] = 8'h11;
    aw_delay = 3; w_delay = 0;
    issue(1'b1, 2'd2, 32'h204, 32'h12345678, 4'b0011, ok, acc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_accept: got timeout expected accept"); end
    n_cmp++; if ({awvalid, wvalid, wlast} !== 3'b111 || wdata !== 32'h12345678 || wstrb !== 4'b0011) begin
      n_bad++; $display("FAIL wr_t1_fields: got v=%b d=%h s=%b expected 111/12345678/0011", {awvalid, wvalid, wlast}, wdata, wstrb); end
    n_cmp++; if (awid !== 4'd1 || wid !== 4'd1 || awsize !== 3'b010 || awburst !== 2'b01) begin
      n_bad++; $display("FAIL wr_ids: got awid=%h wid=%h size=%b burst=%b expected 1/1/010/01", awid, wid, awsize, awburst); end
    hold_ok = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (awvalid !== 1'b1 || awaddr !== 32'h204 || wvalid !== 1'b0 || addr_ok !== 1'b0) hold_ok = 0;
    end
    n_cmp++; if (!hold_ok) begin n_bad++; $display("FAIL wr_aw_hold: got dropped/changed expected awvalid held with wvalid low"); end
    pulses = 0; at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (data_ok === 1'b1) begin pulses++; at = cyc; er = resp_err; end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL wr_single_pulse: got %0d expected 1", pulses); end
    n_cmp++; if (at != acc + 6 || er !== 1'b0) begin n_bad++; $display("FAIL wr_done_cycle: got %0d err=%b expected %0d err=0", at, er, acc + 6); end
    rd = {mem[519], mem[518], mem[517], mem[516]};
    n_cmp++; if (rd !== 32'hAAAA5678 || mem[515] !== 8'h11) begin
      n_bad++; $display("FAIL wr_mem_bytes: got %h/%h expected aaaa5678/11", rd, mem[515]); end
    aw_delay = 0;
  endtask

  task automatic test_back_to_back();
    bit ok; int acc, at, acc2; logic [31:0] rd; logic er;
    for (int i = 8; i < 12; i++) mem[i] = 8'h00;
    issue(1'b1, 2'd0, 32'h8, 32'h00000055, 4'b0001, ok, acc);
    n_cmp++; if (awsize !== 3'b000) begin n_bad++; $display("FAIL b2b_awsize: got %b expected 000", awsize); end
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_write_done: got timeout expected data_ok"); end
    issue(1'b0, 2'd2, 32'h8, 32'h0, 4'h0, ok, acc2);
    n_cmp++; if (!ok || acc2 != at) begin n_bad++; $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc2, at); end
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok || rd !== 32'h00000055) begin n_bad++; $display("FAIL b2b_read_data: got %h expected 00000055", rd); end
    @(negedge aclk);
  endtask

  task automatic test_error();
    bit ok; int acc, at; logic [31:0] rd; logic er;
    b_resp_k = 2'b10;
    issue(1'b1, 2'd2, 32'h10, 32'hCAFEF00D, 4'hF, ok, acc);
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok || er !== 1'b1) begin n_bad++; $display("FAIL err_bresp: got ok=%b err=%b expected 1/1", ok, er); end
    b_resp_k = 2'b00;
    issue(1'b0, 2'd2, 32'h10, 32'h0, 4'h0, ok, acc);
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok || er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL err_clear_read: got err=%b data=%h expected 0/cafef00d", er, rd); end
    // Mismatched RID with OKAY response still flags an error; size 3 maps to 4 bytes.
    r_id_k = 4'd3;
    issue(1'b0, 2'd3, 32'h10, 32'h0, 4'h0, ok, acc);
    n_cmp++; if (arsize !== 3'b010) begin n_bad++; $display("FAIL size3_arsize: got %b expected 010", arsize); end
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok || er !== 1'b1) begin n_bad++; $display("FAIL err_rid: got ok=%b err=%b expected 1/1", ok, er); end
    r_id_k = 4'd0;
    @(negedge aclk);
  endtask

  task automatic test_backpressure();
    bit ok; int acc, at; bit hold_ok; logic [31:0] rd; logic er;
    mem[64] = 8'h01; mem[65] = 8'h02; mem[66] = 8'h03; mem[67] = 8'h04;
    ar_delay = 5;
    issue(1'b0, 2'd2, 32'h40, 32'h0, 4'h0, ok, acc);
    hold_ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (arvalid !== 1'b1 || araddr !== 32'h40 || addr_ok !== 1'b0 || rready !== 1'b0) hold_ok = 0;
      @(negedge aclk);
    end
    n_cmp++; if (!hold_ok) begin n_bad++; $display("FAIL bp_ar_stable: got unstable expected arvalid/araddr held, addr_ok low"); end
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok || at != acc + 8 || rd !== 32'h04030201) begin
      n_bad++; $display("FAIL bp_done: got cycle %0d data %h expected %0d 04030201", at, rd, acc + 8); end
    ar_delay = 0;
    @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    bit ok; int acc, at; bit quiet; logic [31:0] rd; logic er;
    r_delay = 0;
    issue(1'b0, 2'd2, 32'h100, 32'h0, 4'h0, ok, acc);
    @(negedge aclk);
    n_cmp++; if (dbg_state !== ST_RDATA) begin n_bad++; $display("FAIL rst_mid_in_rdata: got %0d expected 2", dbg_state); end
    aresetn = 1'b0;
    @(negedge aclk);
    n_cmp++; if (rready !== 1'b0 || dbg_state !== ST_IDLE || data_ok !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_abandon: got rready=%b state=%0d data_ok=%b expected 0/0/0", rready, dbg_state, data_ok); end
    aresetn = 1'b1;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      if (data_ok !== 1'b0 || rready !== 1'b0) quiet = 0;
    end
    n_cmp++; if (!quiet) begin n_bad++; $display("FAIL rst_mid_no_pulse: got activity expected none"); end
    issue(1'b0, 2'd2, 32'h100, 32'h0, 4'h0, ok, acc);
    wait_done(ok, at, rd, er);
    n_cmp++; if (!ok || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_fresh_read: got %h err=%b expected deadbeef/0", rd, er); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    @(negedge aclk);
    test_reset();
    test_read_zero_wait();
    test_write_w_first();
    test_back_to_back();
    test_error();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
